proyecto_sdram_ctrl: RTL

//  Single-port SDRAM controller sequencing the 16-bit SDR SDRAM (13-bit row, 2-bit bank, 9-bit col).

---
 rtl/proyecto_sdram_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/proyecto_sdram_ctrl.sv
`timescale 1ns/1ps
// SDR SDRAM controller: power-up init, periodic auto-refresh, closed-page single-word read/write.
// All zs_* pins registered; one command per clock, NOPs in between; req_ready only in IDLE.
module proyecto_sdram_ctrl #(
  parameter int CAS_LATENCY    = 3,
  parameter int INIT_CYCLES    = 100,
  parameter int REFRESH_CYCLES = 780,
  parameter int T_RCD          = 2,
  parameter int T_RP           = 2,
  parameter int T_RFC          = 7,
  parameter int T_MRD          = 2,
  parameter int T_WR           = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rdata_valid,
  output logic [15:0] rdata,
  output logic        init_done,
  output logic [12:0] zs_addr,
  output logic [1:0]  zs_ba,
  output logic        zs_cs_n,
  output logic        zs_ras_n,
  output logic        zs_cas_n,
  output logic        zs_we_n,
  output logic        zs_cke,
  output logic [1:0]  zs_dqm,
  inout  wire  [15:0] zs_dq
);

  localparam logic [2:0] CMD_LMR  = 3'b000;
  localparam logic [2:0] CMD_AREF = 3'b001;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_ACT  = 3'b011;
  localparam logic [2:0] CMD_WR   = 3'b100;
  localparam logic [2:0] CMD_RD   = 3'b101;
  localparam logic [2:0] CMD_NOP  = 3'b111;

  localparam logic [15:0] CNT_INIT = 16'(INIT_CYCLES);
  localparam logic [15:0] CNT_RCD  = 16'(T_RCD - 1);
  localparam logic [15:0] CNT_RP   = 16'(T_RP - 1);
  localparam logic [15:0] CNT_RFC  = 16'(T_RFC - 1);
  localparam logic [15:0] CNT_MRD  = 16'(T_MRD - 1);
  localparam logic [15:0] CNT_WR   = 16'(T_WR - 1);
  localparam logic [15:0] CNT_CL   = 16'(CAS_LATENCY - 1);
  localparam logic [15:0] REF_LOAD = 16'(REFRESH_CYCLES - 1);
  // Mode register: burst length 1, sequential, CAS latency in a[6:4].
  localparam logic [12:0] LMR_ADDR = {6'b000_0_00, 3'(CAS_LATENCY), 4'b0_000};

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_LMR,
    S_IDLE, S_REFRESH, S_ACT, S_RCD, S_WR_WAIT, S_RD_WAIT, S_PRE_WAIT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [15:0] r_ref_cnt;
  logic        r_pending, r_init_done, w_init_done_nxt;
  logic [2:0]  r_cmd, w_cmd_nxt;
  logic        r_cs_n, r_cke;
  logic [12:0] r_addr, w_addr_nxt;
  logic [1:0]  r_ba, w_ba_nxt;
  logic [1:0]  r_dqm, w_dqm_nxt;
  logic        r_dq_oe, w_dq_oe_nxt;
  logic [15:0] r_dq_out;
  logic [15:0] r_rdata, w_rdata_nxt;
  logic        r_rdata_valid, w_rdata_valid_nxt;
  logic        w_pending_clr, w_accept, w_cnt_zero, w_req_ready;
  logic        r_we;
  logic [1:0]  r_bank, r_be;
  logic [12:0] r_row;
  logic [8:0]  r_col;
  logic [15:0] r_wdata;

  assign w_cnt_zero  = (r_cnt == 16'd0);
  assign w_req_ready = (r_state == S_IDLE) && r_init_done && !r_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT_WAIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = w_cnt_zero ? r_cnt : r_cnt - 16'd1;
    w_cmd_nxt         = CMD_NOP;
    w_addr_nxt        = r_addr;
    w_ba_nxt          = r_ba;
    w_dqm_nxt         = 2'b11;
    w_dq_oe_nxt       = 1'b0;
    w_rdata_nxt       = r_rdata;
    w_rdata_valid_nxt = 1'b0;
    w_init_done_nxt   = r_init_done;
    w_pending_clr     = 1'b0;
    w_accept          = 1'b0;
    case (r_state)
      S_INIT_WAIT: if (w_cnt_zero) begin
        w_cmd_nxt = CMD_PRE; w_addr_nxt = 13'h0400; w_ba_nxt = 2'b00;
        w_cnt_nxt = CNT_RP;  w_state_nxt = S_INIT_PRE;
      end
      S_INIT_PRE: if (w_cnt_zero) begin
        w_cmd_nxt = CMD_AREF; w_cnt_nxt = CNT_RFC; w_state_nxt = S_INIT_REF1;
      end
      S_INIT_REF1: if (w_cnt_zero) begin
        w_cmd_nxt = CMD_AREF; w_cnt_nxt = CNT_RFC; w_state_nxt = S_INIT_REF2;
      end
      S_INIT_REF2: if (w_cnt_zero) begin
        w_cmd_nxt = CMD_LMR; w_addr_nxt = LMR_ADDR; w_ba_nxt = 2'b00;
        w_cnt_nxt = CNT_MRD; w_state_nxt = S_INIT_LMR;
      end
      S_INIT_LMR: if (w_cnt_zero) begin
        w_state_nxt = S_IDLE; w_init_done_nxt = 1'b1;
      end
      S_IDLE: begin
        if (r_init_done && r_pending) begin
          w_cmd_nxt = CMD_AREF; w_pending_clr = 1'b1;
          w_cnt_nxt = CNT_RFC;  w_state_nxt = S_REFRESH;
        end else if (req_valid && w_req_ready) begin
          w_accept = 1'b1; w_state_nxt = S_ACT;
        end
      end
      S_REFRESH: if (w_cnt_zero) w_state_nxt = S_IDLE;
      S_ACT: begin
        w_cmd_nxt = CMD_ACT; w_addr_nxt = r_row; w_ba_nxt = r_bank;
        w_cnt_nxt = CNT_RCD; w_state_nxt = S_RCD;
      end
      S_RCD: if (w_cnt_zero) begin
        // a[10]=0 keeps the access closed-page only via the explicit PRE that follows.
        w_addr_nxt = {4'b0000, r_col}; w_ba_nxt = r_bank;
        if (r_we) begin
          w_cmd_nxt = CMD_WR; w_dq_oe_nxt = 1'b1; w_dqm_nxt = ~r_be;
          w_cnt_nxt = CNT_WR; w_state_nxt = S_WR_WAIT;
        end else begin
          w_cmd_nxt = CMD_RD; w_dqm_nxt = 2'b00;
          w_cnt_nxt = CNT_CL; w_state_nxt = S_RD_WAIT;
        end
      end
      S_WR_WAIT: if (w_cnt_zero) begin
        w_cmd_nxt = CMD_PRE; w_addr_nxt = 13'h0000; w_ba_nxt = r_bank;
        w_cnt_nxt = CNT_RP;  w_state_nxt = S_PRE_WAIT;
      end
      S_RD_WAIT: begin
        w_dqm_nxt = 2'b00;
        if (w_cnt_zero) begin
          w_rdata_nxt = zs_dq; w_rdata_valid_nxt = 1'b1; w_dqm_nxt = 2'b11;
          w_cmd_nxt = CMD_PRE; w_addr_nxt = 13'h0000; w_ba_nxt = r_bank;
          w_cnt_nxt = CNT_RP;  w_state_nxt = S_PRE_WAIT;
        end
      end
      S_PRE_WAIT: if (w_cnt_zero) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= CNT_INIT;
      r_ref_cnt     <= REF_LOAD;
      r_pending     <= 1'b0;
      r_init_done   <= 1'b0;
      r_cmd         <= CMD_NOP;
      r_cs_n        <= 1'b1;
      r_cke         <= 1'b0;
      r_addr        <= 13'h0000;
      r_ba          <= 2'b00;
      r_dqm         <= 2'b11;
      r_dq_oe       <= 1'b0;
      r_dq_out      <= 16'h0000;
      r_rdata       <= 16'h0000;
      r_rdata_valid <= 1'b0;
      r_we          <= 1'b0;
      r_bank        <= 2'b00;
      r_row         <= 13'h0000;
      r_col         <= 9'h000;
      r_wdata       <= 16'h0000;
      r_be          <= 2'b00;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_init_done   <= w_init_done_nxt;
      r_cmd         <= w_cmd_nxt;
      r_cs_n        <= 1'b0;
      r_cke         <= 1'b1;
      r_addr        <= w_addr_nxt;
      r_ba          <= w_ba_nxt;
      r_dqm         <= w_dqm_nxt;
      r_dq_oe       <= w_dq_oe_nxt;
      r_dq_out      <= r_wdata;
      r_rdata       <= w_rdata_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
      // Timer expiry outranks a same-cycle clear so a refresh is never lost.
      if (r_init_done) begin
        if (r_ref_cnt == 16'd0) begin
          r_ref_cnt <= REF_LOAD;
          r_pending <= 1'b1;
        end else begin
          r_ref_cnt <= r_ref_cnt - 16'd1;
          if (w_pending_clr) r_pending <= 1'b0;
        end
      end
      if (w_accept) begin
        r_we    <= req_we;
        r_bank  <= {req_addr[23], req_addr[9]};
        r_row   <= req_addr[22:10];
        r_col   <= req_addr[8:0];
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
    end
  end

  assign zs_dq       = r_dq_oe ? r_dq_out : 16'hzzzz;
  assign req_ready   = w_req_ready;
  assign rdata_valid = r_rdata_valid;
  assign rdata       = r_rdata;
  assign init_done   = r_init_done;
  assign zs_addr     = r_addr;
  assign zs_ba       = r_ba;
  assign zs_cs_n     = r_cs_n;
  assign zs_ras_n    = r_cmd[2];
  assign zs_cas_n    = r_cmd[1];
  assign zs_we_n     = r_cmd[0];
  assign zs_cke      = r_cke;
  assign zs_dqm      = r_dqm;

endmodule
